// File: rtl/cpu_multicycle_if.sv
// Instruction-memory fetch port: core drives addr/req,
// memory answers with ready/data (wait states allowed).
interface cpu_multicycle_if #(
  parameter int PC_W = 8,
  parameter int IW   = 24
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ready;
  logic [IW-1:0]   imem_data;

  modport master (
    output imem_addr, imem_req,
    input  imem_ready, imem_data
  );

  modport slave (
    input  imem_addr, imem_req,
    output imem_ready, imem_data
  );
endinterface

// File: rtl/cpu_multicycle.sv
// Multicycle CPU: FETCH/DECODE/EXECUTE/WRITEBACK + HALTED.
// Ports: CLK, reset (async low), imem (fetch port, master),
//   ALUResult (last EXECUTE result), cpu_out (R[OUT_REG]),
//   halted (HALT retired), retire (1-cycle pulse per instr).
module cpu_multicycle #(
  parameter int DATA_W  = 8,
  parameter int REG_AW  = 4,
  parameter int PC_W    = 8,
  parameter int OUT_REG = 1,
  parameter int R0_ZERO = 0
) (
  input  logic              CLK,
  input  logic              reset,
  cpu_multicycle_if.master  imem,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] cpu_out,
  output logic              halted,
  output logic              retire
);

  localparam int NREGS = 2**REG_AW;
  localparam int IW    = 4 + 3*REG_AW + DATA_W;
  localparam logic [REG_AW-1:0] OUT_IDX = REG_AW'(OUT_REG);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_SUBI = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALTED
  } state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [IW-1:0]     ir;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              z_q;
  logic [DATA_W-1:0] rf [NREGS];

  logic [3:0]        f_op;
  logic [REG_AW-1:0] f_rd;
  logic [REG_AW-1:0] f_ra;
  logic [REG_AW-1:0] f_rb;
  logic [DATA_W-1:0] f_imm;

  assign f_op  = ir[IW-1 -: 4];
  assign f_rd  = ir[IW-5 -: REG_AW];
  assign f_ra  = ir[IW-5-REG_AW -: REG_AW];
  assign f_rb  = ir[IW-5-2*REG_AW -: REG_AW];
  assign f_imm = ir[DATA_W-1:0];

  logic [DATA_W-1:0] ra_val;
  logic [DATA_W-1:0] rb_val;

  assign ra_val = (R0_ZERO != 0 && f_ra == '0) ? '0 : rf[f_ra];
  assign rb_val = (R0_ZERO != 0 && f_rb == '0) ? '0 : rf[f_rb];

  assign cpu_out = (R0_ZERO != 0 && OUT_IDX == '0)
                 ? '0 : rf[OUT_IDX];

  assign imem.imem_req  = (state == FETCH) && reset;
  assign imem.imem_addr = pc;

  logic [DATA_W-1:0] alu_y;

  always_comb begin
    alu_y = '0;
    case (f_op)
      OP_ADD:  alu_y = a_q + b_q;
      OP_SUB:  alu_y = a_q - b_q;
      OP_AND:  alu_y = a_q & b_q;
      OP_OR:   alu_y = a_q | b_q;
      OP_ADDI: alu_y = a_q + f_imm;
      OP_SUBI: alu_y = a_q - f_imm;
      OP_BEQ:  alu_y = a_q - b_q;
      OP_BNE:  alu_y = a_q - b_q;
      default: alu_y = '0;
    endcase
  end

  logic wr_en;
  logic taken;

  // R0 writes are silently dropped when R0 is hard-wired.
  assign wr_en = (f_op <= OP_SUBI)
              && !(R0_ZERO != 0 && f_rd == '0);
  assign taken = (f_op == OP_BEQ && z_q)
              || (f_op == OP_BNE && !z_q);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= 1'b0;
      ALUResult <= '0;
      halted    <= 1'b0;
      retire    <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (imem.imem_ready) begin
            ir    <= imem.imem_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          a_q   <= ra_val;
          b_q   <= rb_val;
          state <= EXECUTE;
        end
        EXECUTE: begin
          ALUResult <= alu_y;
          z_q       <= (alu_y == '0);
          retire    <= 1'b1;
          state     <= WRITEBACK;
        end
        WRITEBACK: begin
          if (wr_en)
            rf[f_rd] <= ALUResult;
          pc <= taken ? PC_W'(f_imm) : pc + PC_W'(1);
          if (f_op == OP_HALT) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else begin
            state  <= FETCH;
          end
        end
        HALTED: state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: vector table, hand-written
// reset/handshake/halt sequences, random programs vs ISA model.
module tb_cpu_multicycle;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int PW = 8;
  localparam int IW = 24;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  cpu_multicycle_if #(.PC_W(PW), .IW(IW)) bus ();

  logic [DW-1:0] alu_result;
  logic [DW-1:0] cpu_out;
  logic          halted;
  logic          retire;

  cpu_multicycle #(
    .DATA_W(DW), .REG_AW(AW), .PC_W(PW),
    .OUT_REG(1), .R0_ZERO(1)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .imem(bus.master),
    .ALUResult(alu_result),
    .cpu_out(cpu_out),
    .halted(halted),
    .retire(retire)
  );

  logic [IW-1:0] mem [256];
  logic          rdy = 1'b1;
  logic          junk_en = 1'b0;
  bit            rnd_mode = 1'b0;
  logic [IW-1:0] junk;

  assign bus.imem_ready = rdy;
  assign bus.imem_data  = (junk_en && !rdy) ? junk : mem[bus.imem_addr];

  int n_pass = 0;
  int n_total = 0;

  function automatic logic [IW-1:0] enc(
    input logic [3:0] op, input logic [3:0] rd,
    input logic [3:0] ra, input logic [3:0] rb,
    input logic [7:0] imm);
    return {op, rd, ra, rb, imm};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic wait_retire(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (rnd_mode) rdy = ($urandom_range(0, 2) != 0);
      if (retire === 1'b1) begin
        at = cyc;
        return;
      end
    end
    chk("retire_timeout", 0, 1);
  endtask

  task automatic post_check(input string tag,
                            input logic [7:0] out_e,
                            input logic [7:0] pc_e);
    @(negedge CLK);
    if (rnd_mode) rdy = ($urandom_range(0, 2) != 0);
    chk({tag, "_out"}, cpu_out, out_e);
    chk({tag, "_pc"}, bus.imem_addr, pc_e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [7:0]    addr;
    logic [IW-1:0] ins;
    bit            chk_alu;
    logic [7:0]    alu;
    logic [7:0]    out;
    logic [7:0]    npc;
  } vec_t;

  function automatic vec_t mk(
    input logic [7:0] addr, input logic [IW-1:0] ins,
    input bit ca, input logic [7:0] alu,
    input logic [7:0] out, input logic [7:0] npc);
    vec_t v;
    v.addr = addr; v.ins = ins; v.chk_alu = ca;
    v.alu = alu; v.out = out; v.npc = npc;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [18];
    int at, prev, c0, bad;
    logic [7:0] m_r [16];
    logic [7:0] m_pc;
    logic [3:0] ops [9];

    junk = enc(4'h4, 4'h1, 4'h0, 4'h0, 8'h99);

    tv[0]  = mk(8'h00, enc(4'h4, 1, 0, 0, 8'h05), 1, 8'h05, 8'h05, 8'h01);
    tv[1]  = mk(8'h01, enc(4'h4, 2, 0, 0, 8'h03), 1, 8'h03, 8'h05, 8'h02);
    tv[2]  = mk(8'h02, enc(4'h1, 1, 1, 2, 8'h00), 1, 8'h02, 8'h02, 8'h03);
    tv[3]  = mk(8'h03, enc(4'h4, 1, 0, 0, 8'hFF), 1, 8'hFF, 8'hFF, 8'h04);
    tv[4]  = mk(8'h04, enc(4'h4, 1, 1, 0, 8'h02), 1, 8'h01, 8'h01, 8'h05);
    tv[5]  = mk(8'h05, enc(4'h1, 3, 0, 1, 8'h00), 1, 8'hFF, 8'h01, 8'h06);
    tv[6]  = mk(8'h06, enc(4'h4, 1, 0, 0, 8'h07), 1, 8'h07, 8'h07, 8'h07);
    tv[7]  = mk(8'h07, enc(4'h4, 2, 0, 0, 8'h07), 1, 8'h07, 8'h07, 8'h08);
    tv[8]  = mk(8'h08, enc(4'h9, 0, 1, 2, 8'h40), 1, 8'h00, 8'h07, 8'h09);
    tv[9]  = mk(8'h09, enc(4'h8, 0, 1, 2, 8'h20), 1, 8'h00, 8'h07, 8'h20);
    tv[10] = mk(8'h20, enc(4'h3, 1, 1, 3, 8'h00), 1, 8'hFF, 8'hFF, 8'h21);
    tv[11] = mk(8'h21, enc(4'h2, 1, 1, 2, 8'h00), 1, 8'h07, 8'h07, 8'h22);
    tv[12] = mk(8'h22, enc(4'h5, 1, 1, 0, 8'h09), 1, 8'hFE, 8'hFE, 8'h23);
    tv[13] = mk(8'h23, enc(4'h6, 1, 1, 1, 8'h33), 0, 8'h00, 8'hFE, 8'h24);
    tv[14] = mk(8'h24, enc(4'h4, 0, 0, 0, 8'h09), 1, 8'h09, 8'hFE, 8'h25);
    tv[15] = mk(8'h25, enc(4'h0, 1, 0, 0, 8'h00), 1, 8'h00, 8'h00, 8'h26);
    tv[16] = mk(8'h26, enc(4'h8, 0, 0, 0, 8'hFF), 1, 8'h00, 8'h00, 8'hFF);
    tv[17] = mk(8'hFF, enc(4'h4, 1, 1, 0, 8'h01), 1, 8'h01, 8'h01, 8'h00);

    for (int i = 0; i < 256; i++) mem[i] = enc(4'h7, 0, 0, 0, 8'h00);
    foreach (tv[i]) mem[tv[i].addr] = tv[i].ins;

    // reset state
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, 8'h00);
    chk("rst_alu", alu_result, 8'h00);
    chk("rst_out", cpu_out, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retire", retire, 1'b0);

    // vector table
    do_reset();
    #1;
    chk("rel_req", bus.imem_req, 1'b1);
    prev = -1;
    foreach (tv[i]) begin
      wait_retire(at);
      if (tv[i].chk_alu)
        chk($sformatf("tbl%0d_alu", i), alu_result, tv[i].alu);
      if (i > 0)
        chk($sformatf("tbl%0d_gap", i), at - prev, 4);
      prev = at;
      post_check($sformatf("tbl%0d", i), tv[i].out, tv[i].npc);
    end

    // reset in the middle of a stalled fetch
    wait_retire(at);
    post_check("t1_pre", 8'h05, 8'h01);
    rdy = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t1_hold_req", bus.imem_req, 1'b1);
    chk("t1_hold_addr", bus.imem_addr, 8'h01);
    reset = 1'b0;
    #1;
    chk("t1_req", bus.imem_req, 1'b0);
    chk("t1_addr", bus.imem_addr, 8'h00);
    chk("t1_alu", alu_result, 8'h00);
    chk("t1_out", cpu_out, 8'h00);

    // wait states: 3 not-ready cycles, junk on the data bus
    mem[1] = enc(4'hF, 0, 0, 0, 8'h00);
    junk_en = 1'b1;
    @(negedge CLK);
    reset = 1'b1;
    c0 = cyc;
    #1;
    chk("t1_rel_req", bus.imem_req, 1'b1);
    chk("t1_rel_addr", bus.imem_addr, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      chk($sformatf("t5_hold%0d", k),
          {bus.imem_req, retire, bus.imem_addr}, {2'b10, 8'h00});
      if (k == 3) rdy = 1'b1;
    end
    wait_retire(at);
    junk_en = 1'b0;
    chk("t5_retire_cycle", at - c0 + 1, 7);
    chk("t5_alu", alu_result, 8'h05);
    post_check("t5", 8'h05, 8'h01);

    // HALT
    wait_retire(at);
    @(negedge CLK);
    chk("t6_halted", halted, 1'b1);
    chk("t6_req", bus.imem_req, 1'b0);
    bad = 0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.imem_req !== 1'b0 || halted !== 1'b1 ||
          retire !== 1'b0 || cpu_out !== 8'h05) bad++;
    end
    chk("t6_idle_bad", bad, 0);
    reset = 1'b0;
    #1;
    chk("t6_rst_halted", halted, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("t6_rel_req", bus.imem_req, 1'b1);
    chk("t6_rel_addr", bus.imem_addr, 8'h00);

    // random programs against the ISA model
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'h6};
    @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 256; i++)
      mem[i] = enc(ops[$urandom_range(0, 8)],
                   4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)),
                   8'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
    m_pc = 8'h00;
    @(negedge CLK);
    reset = 1'b1;
    rnd_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [IW-1:0] ins;
      logic [3:0] op, rd, ra, rb;
      logic [7:0] imm, av, bv, res;
      bit has_alu, br;
      ins = mem[m_pc];
      {op, rd, ra, rb, imm} = ins;
      av = (ra == 0) ? 8'h00 : m_r[ra];
      bv = (rb == 0) ? 8'h00 : m_r[rb];
      has_alu = 1'b1;
      br = 1'b0;
      res = 8'h00;
      case (op)
        4'h0: res = av + bv;
        4'h1: res = av - bv;
        4'h2: res = av & bv;
        4'h3: res = av | bv;
        4'h4: res = av + imm;
        4'h5: res = av - imm;
        4'h8: begin res = av - bv; br = (res == 0); end
        4'h9: begin res = av - bv; br = (res != 0); end
        default: has_alu = 1'b0;
      endcase
      if (op <= 4'h5 && rd != 0) m_r[rd] = res;
      m_pc = br ? imm : m_pc + 8'h01;
      wait_retire(at);
      if (has_alu) chk($sformatf("rnd%0d_alu", n), alu_result, res);
      post_check($sformatf("rnd%0d", n), m_r[1], m_pc);
    end
    rnd_mode = 1'b0;
    rdy = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
